// File: rtl/pe_mac_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_dbuf
// Description : Systolic-array processing element with a double-buffered
//               signed weight (shadow + active).
//               - The weight shift chain runs down the column.
//               - A shadow->active swap is forwarded one row per cycle.
//               - The signed MAC has a saturate-or-wrap result and a sticky
//                 overflow flag.
//               - The operand is forwarded to the right unless this is a
//                 right-edge PE.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_dbuf #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int PSUM_WIDTH   = 32,
    parameter int HAS_RIGHT    = 1,
    parameter int SAT_EN       = 1
) (
    input  logic                           PE_clk,
    input  logic                           PE_rst_n,
    input  logic                           PE_clr,
    input  logic                           PE_w_valid_up,
    input  logic signed [WEIGHT_WIDTH-1:0] PE_w_data_up,
    output logic                           PE_w_valid_down,
    output logic signed [WEIGHT_WIDTH-1:0] PE_w_data_down,
    input  logic                           PE_swap_in,
    output logic                           PE_swap_out,
    input  logic                           PE_en_left,
    input  logic signed [DATA_WIDTH-1:0]   PE_data_left,
    input  logic signed [PSUM_WIDTH-1:0]   PE_psum_up,
    output logic                           PE_en_right,
    output logic signed [DATA_WIDTH-1:0]   PE_data_right,
    output logic                           PE_en_down,
    output logic signed [PSUM_WIDTH-1:0]   PE_psum_down,
    output logic                           PE_ovf
);

    localparam int C_PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int C_SUM_W  = PSUM_WIDTH + 1;
    localparam logic [PSUM_WIDTH-1:0] C_PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] C_PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

    // Weight buffers and column-direction registers
    logic signed [WEIGHT_WIDTH-1:0] shadow_w_q, shadow_w_d;
    logic                           shadow_full_q, shadow_full_d;
    logic signed [WEIGHT_WIDTH-1:0] active_w_q, active_w_d;
    logic                           w_valid_down_q, w_valid_down_d;
    logic signed [WEIGHT_WIDTH-1:0] w_data_down_q, w_data_down_d;
    logic                           swap_out_q;
    logic                           en_down_q;
    logic signed [PSUM_WIDTH-1:0]   psum_down_q, psum_down_d;
    logic                           ovf_q, ovf_d;

    // MAC datapath
    logic signed [C_PROD_W-1:0]     mac_prod;
    logic signed [C_SUM_W-1:0]      mac_sum;
    logic                           mac_oor;
    logic signed [PSUM_WIDTH-1:0]   mac_result;

    // Full-precision signed product and sum one bit wider than the psum, so
    // an out-of-range result shows up as disagreeing top two bits.
    always_comb begin
        mac_prod = C_PROD_W'(PE_data_left) * C_PROD_W'(active_w_q);
        mac_sum  = C_SUM_W'(mac_prod) + C_SUM_W'(PE_psum_up);
        mac_oor  = mac_sum[C_SUM_W-1] ^ mac_sum[C_SUM_W-2];
        mac_result = mac_sum[PSUM_WIDTH-1:0];
        if (mac_oor && (SAT_EN != 0)) begin
            mac_result = mac_sum[C_SUM_W-1] ? C_PSUM_MIN : C_PSUM_MAX;
        end
    end

    // Next-state for weight shift, swap, MAC result and sticky overflow.
    // A simultaneous swap commits the pre-push shadow value, and a MAC in the
    // swap cycle still multiplies by the pre-swap active weight (mac_prod
    // reads active_w_q).
    always_comb begin
        shadow_w_d     = shadow_w_q;
        shadow_full_d  = shadow_full_q;
        active_w_d     = active_w_q;
        w_valid_down_d = 1'b0;
        w_data_down_d  = w_data_down_q;
        psum_down_d    = psum_down_q;
        ovf_d          = ovf_q;

        if (PE_swap_in) begin
            active_w_d    = shadow_w_q;
            shadow_full_d = 1'b0;
        end
        if (PE_w_valid_up) begin
            shadow_w_d     = PE_w_data_up;
            shadow_full_d  = 1'b1;
            w_data_down_d  = shadow_w_q;
            w_valid_down_d = shadow_full_q;
        end

        if (PE_clr) begin
            ovf_d = 1'b0;
        end
        if (PE_en_left) begin
            psum_down_d = mac_result;
            if (mac_oor) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers; async reset discards loaded weights and pending swaps
    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            shadow_w_q     <= '0;
            shadow_full_q  <= 1'b0;
            active_w_q     <= '0;
            w_valid_down_q <= 1'b0;
            w_data_down_q  <= '0;
            swap_out_q     <= 1'b0;
            en_down_q      <= 1'b0;
            psum_down_q    <= '0;
            ovf_q          <= 1'b0;
        end else begin
            shadow_w_q     <= shadow_w_d;
            shadow_full_q  <= shadow_full_d;
            active_w_q     <= active_w_d;
            w_valid_down_q <= w_valid_down_d;
            w_data_down_q  <= w_data_down_d;
            swap_out_q     <= PE_swap_in;
            en_down_q      <= PE_en_left;
            psum_down_q    <= psum_down_d;
            ovf_q          <= ovf_d;
        end
    end

    assign PE_w_valid_down = w_valid_down_q;
    assign PE_w_data_down  = w_data_down_q;
    assign PE_swap_out     = swap_out_q;
    assign PE_en_down      = en_down_q;
    assign PE_psum_down    = psum_down_q;
    assign PE_ovf          = ovf_q;

    generate
        if (HAS_RIGHT != 0) begin : g_right
            logic                         en_right_q;
            logic signed [DATA_WIDTH-1:0] data_right_q;

            // Operand forwarding to the PE on the right
            always_ff @(posedge PE_clk or negedge PE_rst_n) begin
                if (!PE_rst_n) begin
                    en_right_q   <= 1'b0;
                    data_right_q <= '0;
                end else begin
                    en_right_q <= PE_en_left;
                    if (PE_en_left) begin
                        data_right_q <= PE_data_left;
                    end
                end
            end

            assign PE_en_right   = en_right_q;
            assign PE_data_right = data_right_q;
        end else begin : g_no_right
            assign PE_en_right   = 1'b0;
            assign PE_data_right = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mac_dbuf
// Description : Directed self-checking bench for pe_mac_dbuf.
//               - u_top: saturating PE at the top of a two-row column.
//               - u_bot: saturating PE fed from u_top's weight and swap
//                 outputs.
//               - u_wrap: wrapping PE driven with u_top's stimulus.
//               - u_edge: right-edge PE driven with u_top's stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_dbuf;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int PW = 32;

    logic                 PE_clk = 1'b0;
    logic                 PE_rst_n;
    logic                 clr;
    logic                 w_valid;
    logic signed [WW-1:0] w_data;
    logic                 swap;
    logic                 en;
    logic signed [DW-1:0] data;
    logic signed [PW-1:0] psum;
    logic                 b_en;
    logic signed [DW-1:0] b_data;
    logic signed [PW-1:0] b_psum;

    int tests_run    = 0;
    int tests_failed = 0;

    // Outputs, one set per instance
    logic                 t_wvd, b_wvd, w_wvd, e_wvd;
    logic signed [WW-1:0] t_wdd, b_wdd, w_wdd, e_wdd;
    logic                 t_swo, b_swo, w_swo, e_swo;
    logic                 t_enr, b_enr, w_enr, e_enr;
    logic signed [DW-1:0] t_dr,  b_dr,  w_dr,  e_dr;
    logic                 t_end, b_end, w_end, e_end;
    logic signed [PW-1:0] t_ps,  b_ps,  w_ps,  e_ps;
    logic                 t_ovf, b_ovf, w_ovf, e_ovf;

    always #5 PE_clk = ~PE_clk;

    pe_mac_dbuf #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
                  .HAS_RIGHT(1), .SAT_EN(1)) u_top (
        .PE_clk(PE_clk), .PE_rst_n(PE_rst_n), .PE_clr(clr),
        .PE_w_valid_up(w_valid), .PE_w_data_up(w_data),
        .PE_w_valid_down(t_wvd), .PE_w_data_down(t_wdd),
        .PE_swap_in(swap), .PE_swap_out(t_swo),
        .PE_en_left(en), .PE_data_left(data), .PE_psum_up(psum),
        .PE_en_right(t_enr), .PE_data_right(t_dr),
        .PE_en_down(t_end), .PE_psum_down(t_ps), .PE_ovf(t_ovf));

    pe_mac_dbuf #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
                  .HAS_RIGHT(1), .SAT_EN(1)) u_bot (
        .PE_clk(PE_clk), .PE_rst_n(PE_rst_n), .PE_clr(clr),
        .PE_w_valid_up(t_wvd), .PE_w_data_up(t_wdd),
        .PE_w_valid_down(b_wvd), .PE_w_data_down(b_wdd),
        .PE_swap_in(t_swo), .PE_swap_out(b_swo),
        .PE_en_left(b_en), .PE_data_left(b_data), .PE_psum_up(b_psum),
        .PE_en_right(b_enr), .PE_data_right(b_dr),
        .PE_en_down(b_end), .PE_psum_down(b_ps), .PE_ovf(b_ovf));

    pe_mac_dbuf #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
                  .HAS_RIGHT(1), .SAT_EN(0)) u_wrap (
        .PE_clk(PE_clk), .PE_rst_n(PE_rst_n), .PE_clr(clr),
        .PE_w_valid_up(w_valid), .PE_w_data_up(w_data),
        .PE_w_valid_down(w_wvd), .PE_w_data_down(w_wdd),
        .PE_swap_in(swap), .PE_swap_out(w_swo),
        .PE_en_left(en), .PE_data_left(data), .PE_psum_up(psum),
        .PE_en_right(w_enr), .PE_data_right(w_dr),
        .PE_en_down(w_end), .PE_psum_down(w_ps), .PE_ovf(w_ovf));

    pe_mac_dbuf #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
                  .HAS_RIGHT(0), .SAT_EN(1)) u_edge (
        .PE_clk(PE_clk), .PE_rst_n(PE_rst_n), .PE_clr(clr),
        .PE_w_valid_up(w_valid), .PE_w_data_up(w_data),
        .PE_w_valid_down(e_wvd), .PE_w_data_down(e_wdd),
        .PE_swap_in(swap), .PE_swap_out(e_swo),
        .PE_en_left(en), .PE_data_left(data), .PE_psum_up(psum),
        .PE_en_right(e_enr), .PE_data_right(e_dr),
        .PE_en_down(e_end), .PE_psum_down(e_ps), .PE_ovf(e_ovf));

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge PE_clk);
        #1;
    endtask

    initial begin
        PE_rst_n = 1'b0;
        clr = 1'b0; w_valid = 1'b0; w_data = '0; swap = 1'b0;
        en = 1'b0; data = '0; psum = '0;
        b_en = 1'b0; b_data = '0; b_psum = '0;
        tick();
        tick();

        // Reset state
        chk("rst_psum_down", t_ps, 32'd0);
        chk("rst_en_down", {31'd0, t_end}, 32'd0);
        chk("rst_ovf", {31'd0, t_ovf}, 32'd0);
        chk("rst_w_valid_down", {31'd0, t_wvd}, 32'd0);
        chk("rst_swap_out", {31'd0, t_swo}, 32'd0);
        PE_rst_n = 1'b1;

        // MAC before any swap uses weight 0 and passes psum through
        en = 1'b1; data = 8'sd5; psum = 32'sd100;
        tick();
        chk("first_en_down", {31'd0, t_end}, 32'd1);
        chk("first_psum_down", t_ps, 32'd100);
        chk("first_en_right", {31'd0, t_enr}, 32'd1);
        chk("first_data_right", 32'(t_dr), 32'd5);
        chk("first_ovf", {31'd0, t_ovf}, 32'd0);

        // Right-edge PE with data=-1 held: right side stays 0, down side works
        data = -8'sd1; psum = 32'sd7;
        tick();
        chk("edge_en_right", {31'd0, e_enr}, 32'd0);
        chk("edge_data_right", 32'(e_dr), 32'd0);
        chk("edge_en_down", {31'd0, e_end}, 32'd1);
        chk("edge_psum_down", e_ps, 32'd7);
        tick();
        chk("edge_en_right_hold", {31'd0, e_enr}, 32'd0);

        // en_left low: valids drop, data holds
        en = 1'b0; data = 8'sd9; psum = 32'sd55;
        tick();
        chk("idle_en_down", {31'd0, t_end}, 32'd0);
        chk("idle_psum_hold", t_ps, 32'd7);
        chk("idle_data_right_hold", 32'(t_dr), 32'hFFFF_FFFF);

        // Push 3 then -2 down a two-row column
        w_valid = 1'b1; w_data = 8'sd3;
        tick();
        chk("push1_no_strobe", {31'd0, t_wvd}, 32'd0);
        w_data = -8'sd2;
        tick();
        chk("push2_strobe", {31'd0, t_wvd}, 32'd1);
        chk("push2_data", 32'(t_wdd), 32'd3);
        w_valid = 1'b0;
        tick();
        chk("push_idle_strobe", {31'd0, t_wvd}, 32'd0);
        chk("push_idle_data_hold", 32'(t_wdd), 32'd3);
        swap = 1'b1;
        tick();
        chk("swap_out", {31'd0, t_swo}, 32'd1);
        swap = 1'b0;
        tick();
        chk("bot_swap_out", {31'd0, b_swo}, 32'd1);
        en = 1'b1; data = 8'sd10; psum = 32'sd0;
        b_en = 1'b1; b_data = 8'sd10; b_psum = 32'sd0;
        tick();
        chk("top_weight_m2", t_ps, 32'hFFFF_FFEC);
        chk("bot_weight_3", b_ps, 32'd30);
        en = 1'b0; b_en = 1'b0;

        // active=4, shadow=7; swap and MAC in the same cycle
        w_valid = 1'b1; w_data = 8'sd4;
        tick();
        w_valid = 1'b0; swap = 1'b1;
        tick();
        swap = 1'b0; w_valid = 1'b1; w_data = 8'sd7;
        tick();
        w_valid = 1'b0; swap = 1'b1; en = 1'b1; data = 8'sd2; psum = 32'sd10;
        tick();
        chk("swap_mac_pre", t_ps, 32'd18);
        swap = 1'b0; psum = 32'sd0;
        tick();
        chk("swap_mac_post", t_ps, 32'd14);

        // Swap and push together: active gets old shadow (7), strobe uses old full (0)
        en = 1'b0; swap = 1'b1; w_valid = 1'b1; w_data = 8'sd9;
        tick();
        chk("swap_push_strobe", {31'd0, t_wvd}, 32'd0);
        chk("swap_push_data", 32'(t_wdd), 32'd7);
        swap = 1'b0; w_valid = 1'b0; en = 1'b1; data = 8'sd1; psum = 32'sd0;
        tick();
        chk("swap_push_active", t_ps, 32'd7);
        en = 1'b0;

        // Load weight 127 for the overflow cases
        w_valid = 1'b1; w_data = 8'sd127;
        tick();
        w_valid = 1'b0; swap = 1'b1;
        tick();
        swap = 1'b0;
        chk("pre_ovf_clear", {31'd0, t_ovf}, 32'd0);
        en = 1'b1; data = 8'sd127; psum = 32'h7FFF_FFF0;
        tick();
        chk("sat_pos_psum", t_ps, 32'h7FFF_FFFF);
        chk("sat_pos_ovf", {31'd0, t_ovf}, 32'd1);
        chk("wrap_pos_psum", w_ps, 32'h8000_3EF1);
        chk("wrap_pos_ovf", {31'd0, w_ovf}, 32'd1);
        en = 1'b0; clr = 1'b1;
        tick();
        chk("clr_ovf", {31'd0, t_ovf}, 32'd0);
        en = 1'b1;
        tick();
        chk("clr_vs_set", {31'd0, t_ovf}, 32'd1);
        clr = 1'b1; en = 1'b0;
        tick();
        clr = 1'b0; en = 1'b1; data = -8'sd128; psum = 32'h8000_0000;
        tick();
        chk("sat_neg_psum", t_ps, 32'h8000_0000);
        chk("sat_neg_ovf", {31'd0, t_ovf}, 32'd1);
        chk("wrap_neg_psum", w_ps, 32'h7FFF_C080);
        en = 1'b0;

        // In-range MAC does not touch an already-clear flag
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; data = -8'sd1; psum = 32'sd200;
        tick();
        chk("inrange_psum", t_ps, 32'd73);
        chk("inrange_ovf", {31'd0, t_ovf}, 32'd0);

        // Asynchronous reset clears state without a clock edge
        #2;
        PE_rst_n = 1'b0;
        #1;
        chk("async_rst_psum", t_ps, 32'd0);
        chk("async_rst_en_down", {31'd0, t_end}, 32'd0);
        #2;
        PE_rst_n = 1'b1;
        en = 1'b1; data = 8'sd3; psum = 32'sd1;
        tick();
        chk("post_rst_weight0", t_ps, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
